// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// Pipelined unsigned add/subtract unit. The WIDTH-bit operands are cut into
// CHUNK-bit slices and one slice is resolved per register stage, so the carry
// chain in any single cycle is only CHUNK bits long. Subtraction is done as
// A + ~B + 1 by inverting B and forcing the carry into the lowest slice.
// A single global advance signal moves the whole pipe at once. The pipe is
// never compacted, so bubbles travel through it just like data.
//
// Parameters
//   WIDTH  operand width in bits (must be a multiple of CHUNK)
//   CHUNK  bits resolved per pipeline stage; STAGES = WIDTH / CHUNK
//
// Ports
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   in_valid   in0/in1/sub carry an operation this cycle
//   in_ready   unit accepts an operation this cycle
//   in0, in1   unsigned operands A and B
//   sub        0: A+B, 1: A-B
//   out_valid  out holds a result
//   out_ready  consumer takes the result this cycle
//   out        {carry / not-borrow, sum or difference mod 2^WIDTH}
// -----------------------------------------------------------------------------
module pipelined_adder #(
  parameter int WIDTH = 9,
  parameter int CHUNK = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             adv;
  logic [WIDTH-1:0] b_in;

  // Inter-stage registers; element k is the output of stage k. The final
  // stage writes out_q instead, so element STAGES-1 stays unused.
  logic [WIDTH-1:0] a_p [STAGES];
  logic [WIDTH-1:0] b_p [STAGES];
  logic [WIDTH-1:0] s_p [STAGES];
  logic             c_p [STAGES];
  logic [STAGES-1:0] vld_p;
  logic [WIDTH:0]   out_q;

  // The whole pipe moves whenever the output slot is empty or being drained.
  // A pop and a push can therefore happen on the same edge.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p[STAGES-1];
  assign out       = out_q;

  // Inverting B here and forcing cin=sub in stage 0 gives A + ~B + 1.
  assign b_in = sub ? ~in1 : in1;

  // Valid bits shift with the data. An empty input slot becomes a bubble.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p <= '0;
    end else if (adv) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic             c_in;
    logic [WIDTH-1:0] s_in;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] s_next;

    // ---- stage k input: slice k of the operands plus the incoming carry ----
    if (k == 0) begin : g_head
      assign a_ch = in0[CHUNK-1:0];
      assign b_ch = b_in[CHUNK-1:0];
      assign c_in = sub;
      assign s_in = '0;
    end else begin : g_body
      assign a_ch = a_p[k-1][k*CHUNK +: CHUNK];
      assign b_ch = b_p[k-1][k*CHUNK +: CHUNK];
      assign c_in = c_p[k-1];
      assign s_in = s_p[k-1];
    end

    assign chunk_sum = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, c_in};

    // Lower result slices ride along unchanged so that every slice lands in
    // the output register on the same edge.
    always_comb begin
      s_next = s_in;
      s_next[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // ---- stage k register boundary ----
    if (k < STAGES - 1) begin : g_reg
      logic [WIDTH-1:0] a_fwd;
      logic [WIDTH-1:0] b_fwd;

      if (k == 0) begin : g_fwd_head
        assign a_fwd = in0;
        assign b_fwd = b_in;
      end else begin : g_fwd_body
        assign a_fwd = a_p[k-1];
        assign b_fwd = b_p[k-1];
      end

      // Data registers carry no reset. The valid bits alone decide whether a
      // slot holds anything meaningful.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_p[k] <= a_fwd;
          b_p[k] <= b_fwd;
          s_p[k] <= s_next;
          c_p[k] <= chunk_sum[CHUNK];
        end
      end
    end else begin : g_out
      // The output register is cleared on reset so out reads 0 while idle.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          out_q <= '0;
        end else if (adv) begin
          out_q <= {chunk_sum[CHUNK], s_next};
        end
      end
    end
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit. Successor to the fixed 9-bit ripple adder.
- The operand width is split into CHUNK-bit slices, one slice per register stage, so carry ripples only CHUNK bits per cycle.
- Carries valid/ready handshakes on input and output, and stalls cleanly under backpressure.
- Used wherever the datapath needs wide sums at full clock rate, one result per cycle.

Parameters:
- WIDTH, 9, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 3, bits added per pipeline stage; STAGES = WIDTH/CHUNK (default 3).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  in0/in1/sub are valid this cycle.
- in_ready  output  1  unit accepts an operation this cycle.
- in0  input  WIDTH  operand A, unsigned.
- in1  input  WIDTH  operand B, unsigned.
- sub  input  1  0: A+B; 1: A-B (two's complement, A + ~B + 1).
- out_valid  output  1  out holds a result.
- out_ready  input  1  consumer takes the result this cycle.
- out  output  WIDTH+1  out[WIDTH-1:0] = sum/difference mod 2^WIDTH; out[WIDTH] = carry-out (add) or not-borrow (sub; 1 when A>=B).

Behaviour:
- Reset: while resetn=0, all stage valid bits, out_valid and out clear to 0 immediately, without waiting for clk. in_ready=1 during and after reset.
- Global advance signal: adv = !out_valid || out_ready. in_ready = adv (combinational from out_valid and out_ready).
- Acceptance: an operation is accepted on a rising edge where in_valid && in_ready.
- Stall: when adv=0, every stage register, valid bit, out and out_valid hold their values. No data is lost or duplicated. Inputs are ignored.
- Bubbles are not squeezed out; a bubble moves down the pipe like data.
- Stage 0 on accept:
  - B' = sub ? ~in1 : in1; cin = sub.
  - Register sum of the low CHUNK bits of in0 and B' plus cin, and the resulting carry.
  - Register the upper bits of in0 and B' for later stages.
- Stage k (1..STAGES-1): adds chunk k of the carried-forward operands plus the carry from stage k-1. Lower result chunks are delayed alongside so all chunks align at the output register.
- Latency: a result accepted at edge N is presented with out_valid=1 after edge N+STAGES-1 (i.e. STAGES register stages, STAGES=1 legal, combinational-free output). Default: 3 edges.
- Throughput: one operation per cycle while out_ready=1.
- Output stability: out is valid only when out_valid=1. Its value holds until the edge where out_valid && out_ready.
- Simultaneous pop and push: with the output full and out_ready=1, in_ready=1. The new operation enters and all stages shift in the same edge.
- Wrap-around:
  - Add results exceeding 2^WIDTH-1 wrap in the low WIDTH bits, with out[WIDTH]=1.
  - Subtract with A<B gives the two's-complement difference, with out[WIDTH]=0.
- Reset mid-operation: in-flight operations are discarded. Nothing emerges after reset deasserts until new input is accepted.

Test Plan:
- Add max + 1: in0=511, in1=1, sub=0, out_ready=1. Expect out=10'h200 (low 9 bits 0, carry 1), out_valid pulses 1 cycle, exactly 3 edges after accept.
- Subtract with borrow, then without:
  - 5-7: expect out=10'h1FE (low 0x1FE = -2, out[9]=0).
  - 7-5: expect out=10'h202 (low 2, out[9]=1).
- Streaming: 6 back-to-back ops (1+1, 2+2, 3+3, 100+200, 511+511, 0-1) with in_valid=1 continuously. Expect results 2, 4, 6, 300, 10'h3FE and 10'h1FF on consecutive cycles, with no gaps.
- Backpressure: fill the pipe with 3 ops, then drop out_ready for 2 cycles.
  - Expect in_ready=0, and out/out_valid frozen on the first result.
  - After out_ready=1, all 3 results emerge in order, none duplicated or lost.
- Reset mid-flight: accept 2 ops, assert resetn=0 between edges. Expect out_valid=0 and out=0 immediately (asynchronously), and no stale result after release.
- Parameter sweep: WIDTH=16 CHUNK=4 and WIDTH=8 CHUNK=8. Check 0xFFFF+1 → 17'h10000 with latency 4, and 8'hFF+1 → 9'h100 with latency 1.
